// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode; the head entry drives the decoder.
// Optional same-cycle bypass when empty is enabled by defining IQ_BYPASS_EN.
module inst_queue #(
  parameter int IQ_SIZE_LOG = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        in_pred_taken,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_pred_taken
);
  localparam int DEPTH = 2**IQ_SIZE_LOG;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred_taken;
  } iq_entry_t;

  iq_entry_t                r_mem [DEPTH];
  logic [IQ_SIZE_LOG-1:0]   r_head, r_tail;
  logic [IQ_SIZE_LOG:0]     r_count;

  logic      w_full, w_empty, w_push, w_pop, w_byp_take;
  iq_entry_t w_in_ent, w_head_ent, w_out;

  assign w_full     = (r_count == (IQ_SIZE_LOG+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_in_ent   = '{inst: in_inst, pc: in_pc, pred_taken: in_pred_taken};
  assign w_head_ent = w_empty ? '0 : r_mem[r_head];

`ifdef IQ_BYPASS_EN
  logic w_byp;
  // Empty queue forwards the offered entry; if consumed now it is never written.
  assign w_byp      = w_empty & in_valid & ~flush;
  assign w_byp_take = rdy & w_byp & out_ready;
  assign out_valid  = ~w_empty | w_byp;
  assign w_out      = w_byp ? w_in_ent : w_head_ent;
`else
  assign w_byp_take = 1'b0;
  assign out_valid  = ~w_empty;
  assign w_out      = w_head_ent;
`endif

  assign in_ready       = ~w_full;
  assign w_push         = rdy & in_valid & ~w_full & ~w_byp_take;
  assign w_pop          = rdy & ~w_empty & out_ready;
  assign out_inst       = w_out.inst;
  assign out_pc         = w_out.pc;
  assign out_pred_taken = w_out.pred_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + 1'b1;
        if (w_pop)  r_head <= r_head + 1'b1;
        r_count <= r_count + (IQ_SIZE_LOG+1)'(w_push) - (IQ_SIZE_LOG+1)'(w_pop);
      end
    end
  end

  // Storage is deliberately not reset; the pointers define what is live.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_tail] <= w_in_ent;
  end

endmodule
